ucode_checkpoint_monitor: RTL and testbench

- Watches the micro-sequencer's execution-stage PC/opcode and fetch-stage PC against a runtime-loaded table of NUM_CHECKS checkpoints.
- Reports pass events, issues PC-redirect requests to skip unsupported tests, and detects fail/done labels and cycle-limit timeout.
- Sits beside the cpu in sectest-style benches and FPGA self-test builds. Replaces ad-hoc per-label checks with a parametrised, synthesizable block.

---
 rtl/ckmon_pkg.sv | 52 +++++
 rtl/ckmon_if.sv | 23 ++
 rtl/ckmon_match.sv | 103 ++++++++++
 rtl/ucode_checkpoint_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_ucode_checkpoint_monitor.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ckmon_pkg.sv
// Shared types, opcode field positions and helpers for the microcode checkpoint monitor.
package ckmon_pkg;

    localparam int unsigned CKMON_PC_W = 12;

    localparam logic [3:0] SQI_CONT = 4'd14;
    localparam logic [1:0] MAP_PE   = 2'd0;

    // Positions in the zero-based x_opcode vector (microcode field bit k lives at k-1).
    localparam int unsigned SQI_HI  = 111;
    localparam int unsigned SQI_LO  = 108;
    localparam int unsigned ADDR_HI = 107;
    localparam int unsigned ADDR_LO = 96;
    localparam int unsigned MAP_HI  = 95;
    localparam int unsigned MAP_LO  = 94;

    typedef enum logic [1:0] {
        KindPass = 2'd0,
        KindSkip = 2'd1,
        KindFail = 2'd2,
        KindDone = 2'd3
    } ckmon_kind_e;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StRedir,
        StEndPass,
        StEndFail,
        StEndTmo
    } ckmon_state_e;

    typedef enum logic [1:0] {
        StatusBusy    = 2'd0,
        StatusPass    = 2'd1,
        StatusFail    = 2'd2,
        StatusTimeout = 2'd3
    } ckmon_status_e;

    typedef struct packed {
        logic                  valid;
        ckmon_kind_e           kind;
        logic [CKMON_PC_W-1:0] from;
        logic [CKMON_PC_W-1:0] to;
        logic [CKMON_PC_W-1:0] target;
    } ckmon_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ckmon_if.sv
// Sequencer-side observation and redirect handshake seen by the checkpoint monitor.
interface ckmon_if #(
    parameter int unsigned PC_W = 12,
    parameter int unsigned OP_W = 112
);
    logic            x_valid;
    logic [PC_W-1:0] x_pc;
    logic [OP_W-1:0] x_opcode;
    logic [PC_W-1:0] f_pc;
    logic            redir_valid;
    logic [PC_W-1:0] redir_pc;
    logic            redir_ready;

    modport master (
        output x_valid, x_pc, x_opcode, f_pc, redir_ready,
        input  redir_valid, redir_pc
    );

    modport slave (
        input  x_valid, x_pc, x_opcode, f_pc, redir_ready,
        output redir_valid, redir_pc
    );
endinterface

// File: rtl/ckmon_match.sv
// Combinational checkpoint table compare with per-kind lowest-index priority encoders.
module ckmon_match import ckmon_pkg::*; #(
    parameter int unsigned PC_W       = 12,
    parameter int unsigned OP_W       = 112,
    parameter int unsigned NUM_CHECKS = 16,
    localparam int unsigned IDX_W     = $clog2(NUM_CHECKS),
    localparam int unsigned ENTRY_W   = 3 + 3 * PC_W
) (
    input  logic                  en,
    input  logic [PC_W-1:0]       x_pc,
    input  logic [OP_W-1:0]       x_opcode,
    input  logic [PC_W-1:0]       f_pc,
    input  logic [ENTRY_W-1:0]    tbl [NUM_CHECKS],
    output logic [NUM_CHECKS-1:0] hit_pass,
    output logic                  any_fail,
    output logic                  any_done,
    output logic                  any_skip,
    output logic [IDX_W-1:0]      idx_pass,
    output logic [PC_W-1:0]       skip_target,
    output logic                  win_valid,
    output ckmon_kind_e           win_kind,
    output logic [IDX_W-1:0]      win_idx
);

    typedef struct packed {
        logic            valid;
        ckmon_kind_e     kind;
        logic [PC_W-1:0] from;
        logic [PC_W-1:0] to;
        logic [PC_W-1:0] target;
    } entry_t;

    logic [NUM_CHECKS-1:0] hit_skip, hit_fail, hit_done;
    logic [IDX_W-1:0]      idx_skip, idx_fail, idx_done;
    logic [PC_W-1:0]       addr;
    logic                  pass_op;

    assign addr    = PC_W'(x_opcode[ADDR_HI:ADDR_LO]);
    assign pass_op = (x_opcode[SQI_HI:SQI_LO] == SQI_CONT) && (x_opcode[MAP_HI:MAP_LO] == MAP_PE);

    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_CHECKS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    always_comb begin
        entry_t e;
        e        = '0;
        hit_pass = '0;
        hit_skip = '0;
        hit_fail = '0;
        hit_done = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            e = entry_t'(tbl[i]);
            if (en && e.valid) begin
                case (e.kind)
                    KindPass: hit_pass[i] = pass_op && (addr == e.from);
                    KindSkip: hit_skip[i] = (x_pc == e.from) && (f_pc == e.to);
                    KindFail: hit_fail[i] = (x_pc == e.from);
                    KindDone: hit_done[i] = (x_pc == e.from);
                    default:  ;
                endcase
            end
        end
    end

    assign idx_pass = lowest(hit_pass);
    assign idx_skip = lowest(hit_skip);
    assign idx_fail = lowest(hit_fail);
    assign idx_done = lowest(hit_done);
    assign any_fail = |hit_fail;
    assign any_done = |hit_done;
    assign any_skip = |hit_skip;

    always_comb begin
        entry_t s;
        s           = entry_t'(tbl[idx_skip]);
        skip_target = s.target;
    end

    always_comb begin
        win_valid = 1'b1;
        win_kind  = KindPass;
        win_idx   = idx_pass;
        if (any_fail) begin
            win_kind = KindFail;
            win_idx  = idx_fail;
        end else if (any_done) begin
            win_kind = KindDone;
            win_idx  = idx_done;
        end else if (any_skip) begin
            win_kind = KindSkip;
            win_idx  = idx_skip;
        end else if (!(|hit_pass)) begin
            win_valid = 1'b0;
        end
    end

endmodule

// File: rtl/ucode_checkpoint_monitor.sv
// Checkpoint monitor top: table registers, run FSM, watchdog, events and counters.
// Define CKMON_ORDER_EN to require PASS checkpoints in ascending table order.
module ucode_checkpoint_monitor import ckmon_pkg::*; #(
    parameter int unsigned PC_W       = 12,
    parameter int unsigned OP_W       = 112,
    parameter int unsigned NUM_CHECKS = 16,
    parameter int unsigned LIMIT_W    = 32,
    localparam int unsigned IDX_W     = $clog2(NUM_CHECKS),
    localparam int unsigned ENTRY_W   = 2 + 3 * PC_W + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ckmon_if.slave                bus,
    input  logic                  tbl_we,
    input  logic [IDX_W-1:0]      tbl_idx,
    input  logic [ENTRY_W-1:0]    tbl_entry,
    input  logic [LIMIT_W-1:0]    limit,
    input  logic                  start,
    input  logic                  clear,
    output logic                  evt_valid,
    output logic [1:0]            evt_kind,
    output logic [IDX_W-1:0]      evt_idx,
    output logic [NUM_CHECKS-1:0] pass_mask,
    output logic [15:0]           pass_count,
    output logic [15:0]           skip_count,
    output logic [1:0]            status,
    output logic                  done
);

    ckmon_state_e          state_q, state_d;
    logic [ENTRY_W-1:0]    tbl_q [NUM_CHECKS];
    logic [LIMIT_W-1:0]    limit_q, limit_d, cnt_q, cnt_d;
    logic                  evt_valid_q, evt_valid_d;
    ckmon_kind_e           evt_kind_q, evt_kind_d;
    logic [IDX_W-1:0]      evt_idx_q, evt_idx_d;
    logic [NUM_CHECKS-1:0] pass_mask_q, pass_mask_d;
    logic [15:0]           pass_cnt_q, pass_cnt_d, skip_cnt_q, skip_cnt_d;
    logic [PC_W-1:0]       redir_pc_q, redir_pc_d;
    ckmon_status_e         status_s;

    logic [NUM_CHECKS-1:0] hit_pass;
    logic                  any_fail, any_done, any_skip, win_valid, order_err, tmo;
    logic [IDX_W-1:0]      idx_pass, win_idx;
    logic [PC_W-1:0]       skip_target;
    ckmon_kind_e           win_kind;

    ckmon_match #(
        .PC_W       (PC_W),
        .OP_W       (OP_W),
        .NUM_CHECKS (NUM_CHECKS)
    ) u_match (
        .en          (state_q == StRun && bus.x_valid),
        .x_pc        (bus.x_pc),
        .x_opcode    (bus.x_opcode),
        .f_pc        (bus.f_pc),
        .tbl         (tbl_q),
        .hit_pass    (hit_pass),
        .any_fail    (any_fail),
        .any_done    (any_done),
        .any_skip    (any_skip),
        .idx_pass    (idx_pass),
        .skip_target (skip_target),
        .win_valid   (win_valid),
        .win_kind    (win_kind),
        .win_idx     (win_idx)
    );

`ifdef CKMON_ORDER_EN
    logic [IDX_W-1:0] last_idx_q, last_idx_d;

    assign order_err = (|hit_pass) && (idx_pass < last_idx_q);

    always_comb begin
        last_idx_d = last_idx_q;
        if (state_q == StIdle && start) begin
            last_idx_d = '0;
        end else if (|hit_pass && !order_err) begin
            last_idx_d = idx_pass;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_idx_q <= '0;
        else          last_idx_q <= last_idx_d;
    end
`else
    assign order_err = 1'b0;
`endif

    // limit of zero disables the watchdog; the counter is left free-running.
    assign tmo = (limit_q != '0) && (cnt_q == limit_q - LIMIT_W'(1));

    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        cnt_d       = cnt_q;
        evt_valid_d = 1'b0;
        evt_kind_d  = evt_kind_q;
        evt_idx_d   = evt_idx_q;
        pass_mask_d = pass_mask_q;
        pass_cnt_d  = pass_cnt_q;
        skip_cnt_d  = skip_cnt_q;
        redir_pc_d  = redir_pc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRun;
                    limit_d     = limit;
                    cnt_d       = '0;
                    pass_mask_d = '0;
                    pass_cnt_d  = '0;
                    skip_cnt_d  = '0;
                end
            end
            StRun: begin
                cnt_d = cnt_q + LIMIT_W'(1);
                if (win_valid) begin
                    evt_valid_d = 1'b1;
                    evt_kind_d  = win_kind;
                    evt_idx_d   = win_idx;
                end
                if (order_err && !any_fail) begin
                    evt_kind_d = KindFail;
                    evt_idx_d  = idx_pass;
                end
                if (|hit_pass && !order_err) begin
                    pass_mask_d = pass_mask_q | hit_pass;
                    pass_cnt_d  = sat_inc16(pass_cnt_q);
                end
                if (any_fail || order_err) begin
                    state_d = StEndFail;
                end else if (any_done) begin
                    state_d = StEndPass;
                end else if (tmo) begin
                    state_d = StEndTmo;
                end else if (any_skip) begin
                    state_d    = StRedir;
                    redir_pc_d = skip_target;
                    skip_cnt_d = sat_inc16(skip_cnt_q);
                end
            end
            StRedir: begin
                cnt_d = cnt_q + LIMIT_W'(1);
                if (tmo) begin
                    state_d = StEndTmo;
                end else if (bus.redir_ready) begin
                    state_d = StRun;
                end
            end
            StEndPass, StEndFail, StEndTmo: begin
                if (clear) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            limit_q     <= '0;
            cnt_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_kind_q  <= KindPass;
            evt_idx_q   <= '0;
            pass_mask_q <= '0;
            pass_cnt_q  <= '0;
            skip_cnt_q  <= '0;
            redir_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            cnt_q       <= cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_kind_q  <= evt_kind_d;
            evt_idx_q   <= evt_idx_d;
            pass_mask_q <= pass_mask_d;
            pass_cnt_q  <= pass_cnt_d;
            skip_cnt_q  <= skip_cnt_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CHECKS; i++) tbl_q[i] <= '0;
        end else if (tbl_we && state_q == StIdle) begin
            tbl_q[tbl_idx] <= tbl_entry;
        end
    end

    always_comb begin
        status_s = StatusBusy;
        case (state_q)
            StEndPass: status_s = StatusPass;
            StEndFail: status_s = StatusFail;
            StEndTmo:  status_s = StatusTimeout;
            default:   status_s = StatusBusy;
        endcase
    end

    assign status          = status_s;
    assign done            = (state_q == StEndPass) || (state_q == StEndFail) ||
                             (state_q == StEndTmo);
    assign evt_valid       = evt_valid_q;
    assign evt_kind        = evt_kind_q;
    assign evt_idx         = evt_idx_q;
    assign pass_mask       = pass_mask_q;
    assign pass_count      = pass_cnt_q;
    assign skip_count      = skip_cnt_q;
    assign bus.redir_valid = (state_q == StRedir);
    assign bus.redir_pc    = redir_pc_q;

endmodule

// File: tb/tb_ucode_checkpoint_monitor.sv
// Scoreboard bench for ucode_checkpoint_monitor: expected events queued by stimulus, popped by a monitor.
module tb_ucode_checkpoint_monitor;
    import ckmon_pkg::*;

    localparam int unsigned PC_W       = 12;
    localparam int unsigned OP_W       = 112;
    localparam int unsigned NUM_CHECKS = 16;
    localparam int unsigned LIMIT_W    = 32;
    localparam int unsigned IDX_W      = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  tbl_we;
    logic [IDX_W-1:0]      tbl_idx;
    logic [2+3*PC_W:0]     tbl_entry;
    logic [LIMIT_W-1:0]    limit;
    logic                  start, clear;
    logic                  evt_valid;
    logic [1:0]            evt_kind;
    logic [IDX_W-1:0]      evt_idx;
    logic [NUM_CHECKS-1:0] pass_mask;
    logic [15:0]           pass_count, skip_count;
    logic [1:0]            status;
    logic                  done;

    always #5 clk = ~clk;

    ckmon_if #(.PC_W(PC_W), .OP_W(OP_W)) bus ();

    ucode_checkpoint_monitor #(
        .PC_W(PC_W), .OP_W(OP_W), .NUM_CHECKS(NUM_CHECKS), .LIMIT_W(LIMIT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
        .limit(limit), .start(start), .clear(clear),
        .evt_valid(evt_valid), .evt_kind(evt_kind), .evt_idx(evt_idx),
        .pass_mask(pass_mask), .pass_count(pass_count), .skip_count(skip_count),
        .status(status), .done(done)
    );

    typedef struct packed {
        logic [1:0]       kind;
        logic [IDX_W-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every event strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && evt_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: got kind %0d idx %0d, required none",
                         evt_kind, evt_idx);
            end else begin
                mon_e = exp_q.pop_front();
                check("evt_kind", 32'(evt_kind), 32'(mon_e.kind));
                check("evt_idx", 32'(evt_idx), 32'(mon_e.idx));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input logic [1:0] k, input int idx);
        exp_t e;
        e.kind = k;
        e.idx  = IDX_W'(idx);
        exp_q.push_back(e);
    endtask

    task automatic write_entry(input int idx, input logic v, input ckmon_kind_e k,
                               input logic [11:0] fr, input logic [11:0] too,
                               input logic [11:0] tg);
        ckmon_entry_t e;
        e.valid   = v;
        e.kind    = k;
        e.from    = fr;
        e.to      = too;
        e.target  = tg;
        tbl_idx   = IDX_W'(idx);
        tbl_entry = e;
        tbl_we    = 1'b1;
        tick(1);
        tbl_we    = 1'b0;
    endtask

    function automatic logic [OP_W-1:0] pass_op(input logic [11:0] a);
        logic [OP_W-1:0] op;
        op           = '0;
        op[111:108]  = 4'd14;
        op[107:96]   = a;
        op[95:94]    = 2'd0;
        return op;
    endfunction

    task automatic drive_x(input logic v, input logic [11:0] pc, input logic [11:0] fpc,
                           input logic [OP_W-1:0] op);
        bus.x_valid  = v;
        bus.x_pc     = pc;
        bus.f_pc     = fpc;
        bus.x_opcode = op;
    endtask

    task automatic start_run(input logic [LIMIT_W-1:0] lim);
        limit = lim;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        tbl_we = 1'b0; tbl_idx = '0; tbl_entry = '0;
        limit = '0; start = 1'b0; clear = 1'b0;
        bus.redir_ready = 1'b0;
        drive_x(1'b0, 12'd0, 12'd0, '0);
        tick(3);
        reset_n = 1'b1;
        tick(1);

        check("reset_status", 32'(status), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_evt_valid", 32'(evt_valid), 32'd0);
        check("reset_redir_valid", 32'(bus.redir_valid), 32'd0);
        check("reset_pass_mask", 32'(pass_mask), 32'd0);
        check("reset_pass_count", 32'(pass_count), 32'd0);
        check("reset_skip_count", 32'(skip_count), 32'd0);

        write_entry(0, 1'b1, KindPass, 12'd12, 12'd0, 12'd0);
        write_entry(1, 1'b1, KindSkip, 12'd0, 12'd1, 12'd8);
        write_entry(2, 1'b1, KindFail, 12'd1666, 12'd0, 12'd0);
        write_entry(3, 1'b1, KindDone, 12'd1666, 12'd0, 12'd0);
        start_run('0);

        // PASS on entry 0
        drive_x(1'b1, 12'd100, 12'd101, pass_op(12'd12));
        expect_evt(2'd0, 0);
        tick(1);
        drive_x(1'b0, 12'd100, 12'd101, '0);
        check("pass_mask_e0", 32'(pass_mask), 32'h1);
        check("pass_count_1", 32'(pass_count), 32'd1);
        check("status_run", 32'(status), 32'd0);

        // SKIP with redirect held while ready is low; stale pipeline keeps matching
        drive_x(1'b1, 12'd0, 12'd1, '0);
        expect_evt(2'd1, 1);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            check("redir_valid_held", 32'(bus.redir_valid), 32'd1);
            check("redir_pc_held", 32'(bus.redir_pc), 32'd8);
            if (i == 2) begin
                bus.redir_ready = 1'b1;
                bus.x_valid     = 1'b0;
            end
            tick(1);
        end
        bus.redir_ready = 1'b0;
        check("redir_released", 32'(bus.redir_valid), 32'd0);
        check("skip_count_1", 32'(skip_count), 32'd1);

        drive_x(1'b1, 12'd200, 12'd201, pass_op(12'd12));
        expect_evt(2'd0, 0);
        tick(1);
        drive_x(1'b0, 12'd0, 12'd0, '0);
        check("pass_count_after_redir", 32'(pass_count), 32'd2);

        // FAIL and DONE on the same cycle: FAIL wins
        drive_x(1'b1, 12'd1666, 12'd0, '0);
        expect_evt(2'd2, 2);
        tick(1);
        check("fail_status", 32'(status), 32'd2);
        check("fail_done", 32'(done), 32'd1);
        tick(2);
        drive_x(1'b0, 12'd0, 12'd0, '0);
        check("fail_status_held", 32'(status), 32'd2);
        write_entry(4, 1'b1, KindFail, 12'd77, 12'd0, 12'd0);
        pulse_clear();
        check("clear_status", 32'(status), 32'd0);
        check("clear_done", 32'(done), 32'd0);

        // Timeout at limit=100; x_pc=77 must not hit the entry dropped outside IDLE
        start_run(32'd100);
        drive_x(1'b1, 12'd77, 12'd0, '0);
        tick(99);
        check("tmo_not_yet", 32'(status), 32'd0);
        tick(1);
        check("tmo_status", 32'(status), 32'd3);
        check("tmo_done", 32'(done), 32'd1);
        drive_x(1'b0, 12'd0, 12'd0, '0);
        pulse_clear();

        // DONE on cycle 100 beats the timeout
        write_entry(2, 1'b0, KindFail, 12'd1666, 12'd0, 12'd0);
        start_run(32'd100);
        tick(99);
        check("done_not_yet", 32'(status), 32'd0);
        drive_x(1'b1, 12'd1666, 12'd0, '0);
        expect_evt(2'd3, 3);
        tick(1);
        drive_x(1'b0, 12'd0, 12'd0, '0);
        check("done_beats_tmo", 32'(status), 32'd1);
        pulse_clear();

        // Descending PASS order
        write_entry(5, 1'b1, KindPass, 12'd50, 12'd0, 12'd0);
        write_entry(3, 1'b1, KindPass, 12'd30, 12'd0, 12'd0);
        start_run('0);
        drive_x(1'b1, 12'd300, 12'd301, pass_op(12'd50));
        expect_evt(2'd0, 5);
        tick(1);
        drive_x(1'b1, 12'd300, 12'd301, pass_op(12'd30));
`ifdef CKMON_ORDER_EN
        expect_evt(2'd2, 3);
`else
        expect_evt(2'd0, 3);
`endif
        tick(1);
        drive_x(1'b0, 12'd0, 12'd0, '0);
`ifdef CKMON_ORDER_EN
        check("order_fail_status", 32'(status), 32'd2);
        pulse_clear();
        start_run('0);
`else
        check("order_pass_count", 32'(pass_count), 32'd2);
        check("order_status_run", 32'(status), 32'd0);
        check("order_pass_mask", 32'(pass_mask), 32'h28);
`endif

        // Asynchronous reset in the middle of a redirect
        drive_x(1'b1, 12'd0, 12'd1, '0);
        expect_evt(2'd1, 1);
        tick(1);
        drive_x(1'b0, 12'd0, 12'd0, '0);
        check("redir_before_reset", 32'(bus.redir_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("redir_async_drop", 32'(bus.redir_valid), 32'd0);
        check("reset_skip_count_2", 32'(skip_count), 32'd0);
        check("reset_pass_count_2", 32'(pass_count), 32'd0);
        check("reset_pass_mask_2", 32'(pass_mask), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        start_run('0);
        drive_x(1'b1, 12'd0, 12'd1, '0);
        tick(2);
        drive_x(1'b0, 12'd0, 12'd0, '0);
        check("table_invalid_no_redir", 32'(bus.redir_valid), 32'd0);
        check("table_invalid_skip_count", 32'(skip_count), 32'd0);
        tick(2);

        check("events_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
